// File: rtl/cont999_seq_if.sv
// Board/counter-side signal bundle for the cont999 sequencer.
// master = sequencer, slave = buttons/switches plus the BCD counter datapath.
`timescale 1ns/1ps
interface cont999_seq_if;
   logic       btn_start;
   logic       dir_sel;
   logic       load;
   logic [3:0] preset1, preset2, preset3;
   logic [3:0] d1, d2, d3;
   logic       cnt_en;
   logic       cnt_dir;
   logic       cnt_clr;
   logic       cnt_ld;
   logic [3:0] ld1, ld2, ld3;
   logic [1:0] state;
   logic       done;

   modport master (
      input  btn_start, dir_sel, load, preset1, preset2, preset3, d1, d2, d3,
      output cnt_en, cnt_dir, cnt_clr, cnt_ld, ld1, ld2, ld3, state, done
   );

   modport slave (
      output btn_start, dir_sel, load, preset1, preset2, preset3, d1, d2, d3,
      input  cnt_en, cnt_dir, cnt_clr, cnt_ld, ld1, ld2, ld3, state, done
   );
endinterface

// File: rtl/cont999_seq.sv
// Start/pause sequencer for the 000-999 BCD up/down counter.
// Optional macro CONT999_AUTORELOAD_EN: restart automatically from DONE on prescaler wrap.
//
// state  | meaning
// IDLE   | stopped, load/direction accepted, waiting for start
// RUN    | prescaler running, cnt_en on each wrap, watching for terminal count
// PAUSE  | prescaler frozen at its current value, direction follows dir_sel
// DONE   | terminal count reached, waiting for start (or reload)
`timescale 1ns/1ps
module cont999_seq #(
   parameter int unsigned TICK_DIV = 25000000,
   parameter int unsigned TICK_W   = 25
) (
   input  logic          clk,
   input  logic          rst,
   cont999_seq_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t              r_state, w_nxt_state;
   logic                r_sync1, r_sync2, r_sync_d;
   logic [3:0]          r_tgt1, r_tgt2, r_tgt3;
   logic [TICK_W-1:0]   r_presc, w_nxt_presc, w_presc_inc;
   logic                r_cnt_en, r_cnt_clr, r_cnt_ld, r_cnt_dir, r_done;
   logic                w_nxt_en, w_nxt_clr, w_nxt_ld, w_nxt_dir;
   logic [3:0]          r_ld1, r_ld2, r_ld3;
   logic [3:0]          w_nxt_ld1, w_nxt_ld2, w_nxt_ld3;
   logic                w_start_evt, w_load_ok, w_match, w_busy, w_wrap;

   function automatic logic [3:0] f_clamp(input logic [3:0] v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction

   assign w_start_evt = r_sync2 & ~r_sync_d;
   assign w_load_ok   = bus.load && (r_state != S_RUN);
   assign w_wrap      = (r_presc == TICK_W'(TICK_DIV - 1));
   assign w_presc_inc = w_wrap ? '0 : r_presc + TICK_W'(1);
   // Digits lag any strobe by one cycle, so a match is only trusted when none is in flight.
   assign w_busy      = r_cnt_en | r_cnt_clr | r_cnt_ld;
   assign w_match     = r_cnt_dir ? ({bus.d3, bus.d2, bus.d1} == 12'h000)
                                  : ({bus.d3, bus.d2, bus.d1} == {r_tgt3, r_tgt2, r_tgt1});

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_presc = r_presc;
      w_nxt_en    = 1'b0;
      w_nxt_clr   = 1'b0;
      w_nxt_ld    = 1'b0;
      w_nxt_ld1   = r_ld1;
      w_nxt_ld2   = r_ld2;
      w_nxt_ld3   = r_ld3;
      w_nxt_dir   = ((r_state == S_IDLE) || (r_state == S_PAUSE)) ? bus.dir_sel : r_cnt_dir;

      if (w_load_ok) begin
         w_nxt_state = S_IDLE;
         w_nxt_presc = '0;
         w_nxt_ld    = 1'b1;
         w_nxt_ld1   = f_clamp(bus.preset1);
         w_nxt_ld2   = f_clamp(bus.preset2);
         w_nxt_ld3   = f_clamp(bus.preset3);
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start_evt) begin
                  w_nxt_state = S_RUN;
                  w_nxt_presc = '0;
               end
            end
            S_RUN: begin
               if (w_start_evt) begin
                  w_nxt_state = S_PAUSE;
               end else if (w_match && !w_busy) begin
                  w_nxt_state = S_DONE;
                  w_nxt_presc = '0;
               end else begin
                  w_nxt_presc = w_presc_inc;
                  w_nxt_en    = w_wrap;
               end
            end
            S_PAUSE: begin
               if (w_start_evt) w_nxt_state = S_RUN;
            end
            S_DONE: begin
               if (w_start_evt) begin
                  w_nxt_state = S_IDLE;
                  w_nxt_clr   = ~r_cnt_dir;
                  w_nxt_ld    = r_cnt_dir;
                  w_nxt_ld1   = r_tgt1;
                  w_nxt_ld2   = r_tgt2;
                  w_nxt_ld3   = r_tgt3;
               end
`ifdef CONT999_AUTORELOAD_EN
               else if (w_wrap) begin
                  w_nxt_state = S_RUN;
                  w_nxt_presc = '0;
                  w_nxt_clr   = ~r_cnt_dir;
                  w_nxt_ld    = r_cnt_dir;
                  w_nxt_ld1   = r_tgt1;
                  w_nxt_ld2   = r_tgt2;
                  w_nxt_ld3   = r_tgt3;
               end else begin
                  w_nxt_presc = w_presc_inc;
               end
`endif
            end
            default: w_nxt_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_sync_d  <= 1'b0;
         r_tgt1    <= 4'd0;
         r_tgt2    <= 4'd0;
         r_tgt3    <= 4'd0;
         r_presc   <= '0;
         r_cnt_en  <= 1'b0;
         r_cnt_clr <= 1'b0;
         r_cnt_ld  <= 1'b0;
         r_cnt_dir <= 1'b0;
         r_ld1     <= 4'd0;
         r_ld2     <= 4'd0;
         r_ld3     <= 4'd0;
         r_done    <= 1'b0;
      end else begin
         r_sync1   <= bus.btn_start;
         r_sync2   <= r_sync1;
         r_sync_d  <= r_sync2;
         if (w_load_ok) begin
            r_tgt1 <= f_clamp(bus.preset1);
            r_tgt2 <= f_clamp(bus.preset2);
            r_tgt3 <= f_clamp(bus.preset3);
         end
         r_state   <= w_nxt_state;
         r_presc   <= w_nxt_presc;
         r_cnt_en  <= w_nxt_en;
         r_cnt_clr <= w_nxt_clr;
         r_cnt_ld  <= w_nxt_ld;
         r_cnt_dir <= w_nxt_dir;
         r_ld1     <= w_nxt_ld1;
         r_ld2     <= w_nxt_ld2;
         r_ld3     <= w_nxt_ld3;
         r_done    <= (w_nxt_state == S_DONE);
      end
   end

   assign bus.cnt_en  = r_cnt_en;
   assign bus.cnt_clr = r_cnt_clr;
   assign bus.cnt_ld  = r_cnt_ld;
   assign bus.cnt_dir = r_cnt_dir;
   assign bus.ld1     = r_ld1;
   assign bus.ld2     = r_ld2;
   assign bus.ld3     = r_ld3;
   assign bus.state   = r_state;
   assign bus.done    = r_done;

endmodule

// File: tb/tb_cont999_seq.sv
// Directed bench for cont999_seq with a behavioural BCD counter closing the loop.
`timescale 1ns/1ps
module tb_cont999_seq;

   logic clk;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   en_cnt = 0;
   int   strobe_cnt = 0;
   int   viol = 0;
   bit   prev_strobe = 0;
   int   m_val;

   cont999_seq_if u_if ();

   cont999_seq #(.TICK_DIV(4), .TICK_W(3)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // counter datapath model
   always @(posedge clk or negedge rst) begin
      if (!rst) m_val <= 0;
      else if (u_if.cnt_clr) m_val <= 0;
      else if (u_if.cnt_ld)
         m_val <= int'(u_if.ld3) * 100 + int'(u_if.ld2) * 10 + int'(u_if.ld1);
      else if (u_if.cnt_en)
         m_val <= u_if.cnt_dir ? (m_val + 999) % 1000 : (m_val + 1) % 1000;
   end
   assign u_if.d1 = 4'(m_val % 10);
   assign u_if.d2 = 4'((m_val / 10) % 10);
   assign u_if.d3 = 4'(m_val / 100);

   always @(negedge clk) begin
      int s;
      if (!rst) prev_strobe = 0;
      else begin
         s = int'(u_if.cnt_en) + int'(u_if.cnt_clr) + int'(u_if.cnt_ld);
         if (s > 1) viol++;
         if (s != 0 && prev_strobe) viol++;
         prev_strobe = (s != 0);
         if (u_if.cnt_en) en_cnt++;
         strobe_cnt += s;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // all tasks below are entered and left on a falling edge
   task automatic press();
      u_if.btn_start = 1'b1;
      repeat (3) @(negedge clk);
      u_if.btn_start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
      int k = 0;
      while (u_if.state !== s && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, u_if.state, s);
   endtask

   task automatic wait_en(input int budget, output int t);
      int k = 0;
      while (u_if.cnt_en !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      t = (u_if.cnt_en === 1'b1) ? cyc : -1000;
   endtask

   task automatic do_load(input logic [3:0] p1, input logic [3:0] p2, input logic [3:0] p3);
      u_if.preset1 = p1;
      u_if.preset2 = p2;
      u_if.preset3 = p3;
      u_if.load = 1'b1;
      @(negedge clk);
      u_if.load = 1'b0;
   endtask

   initial begin
      int base, t_run, t1, t2;
      rst = 1'b0;
      u_if.btn_start = 1'b0;
      u_if.dir_sel = 1'b0;
      u_if.load = 1'b0;
      u_if.preset1 = 4'd0;
      u_if.preset2 = 4'd0;
      u_if.preset3 = 4'd0;

      // reset values, then quiet after release
      repeat (3) @(negedge clk);
      chk("rst_state", u_if.state, 2'b00);
      chk("rst_strobes", {u_if.cnt_en, u_if.cnt_clr, u_if.cnt_ld}, 3'b000);
      chk("rst_dir_done", {u_if.cnt_dir, u_if.done}, 2'b00);
      chk("rst_ld", {u_if.ld3, u_if.ld2, u_if.ld1}, 12'h000);
      rst = 1'b1;
      #1 base = strobe_cnt;
      idle(20);
      #1 chk("idle_no_strobe", strobe_cnt - base, 0);
      chk("idle_state", u_if.state, 2'b00);

      // up to 002: load puts the counter at the target, so RUN exits at once
      do_load(4'd2, 4'd0, 4'd0);
      chk("t2_ld_strobe", u_if.cnt_ld, 1'b1);
      chk("t2_ld_val", {u_if.ld3, u_if.ld2, u_if.ld1}, 12'h002);
      idle(1);
      #1 base = en_cnt;
      press();
      chk("t2_run", u_if.state, 2'b01);
      wait_state(2'b11, 4, "t2_entry_done");
      #1 chk("t2_entry_no_en", en_cnt - base, 0);
      idle(4);
      press();
      chk("t2_done_to_idle", u_if.state, 2'b00);
      chk("t2_clr", u_if.cnt_clr, 1'b1);
      idle(4);
      chk("t2_cleared", m_val, 0);
      #1 base = en_cnt;
      press();
      t_run = cyc;
      chk("t2_run2", u_if.state, 2'b01);
      wait_en(10, t1);
      chk("t2_first_en", t1 - t_run, 4);
      @(negedge clk);
      wait_en(10, t2);
      chk("t2_en_gap", t2 - t1, 4);
      wait_state(2'b11, 10, "t2_done");
      chk("t2_done_flag", u_if.done, 1'b1);
      chk("t2_digits", {u_if.d3, u_if.d2, u_if.d1}, 12'h002);
      #1 chk("t2_en_count", en_cnt - base, 2);

      // down from 005 to 000
      @(negedge clk);
      u_if.dir_sel = 1'b1;
      @(negedge clk);
      chk("t3_dir_frozen_done", u_if.cnt_dir, 1'b0);
      do_load(4'd5, 4'd0, 4'd0);
      chk("t3_ld_strobe", u_if.cnt_ld, 1'b1);
      chk("t3_ld_val", {u_if.ld3, u_if.ld2, u_if.ld1}, 12'h005);
      chk("t3_load_idle", u_if.state, 2'b00);
      @(negedge clk);
      chk("t3_dir_follow", u_if.cnt_dir, 1'b1);
      idle(2);
      #1 base = en_cnt;
      press();
      chk("t3_run", u_if.state, 2'b01);
      wait_state(2'b11, 60, "t3_done");
      chk("t3_zero", {u_if.d3, u_if.d2, u_if.d1}, 12'h000);
      #1 chk("t3_en_count", en_cnt - base, 5);
      idle(4);
      press();
      chk("t3_reload_idle", u_if.state, 2'b00);
      chk("t3_reload_ld", u_if.cnt_ld, 1'b1);
      chk("t3_reload_val", {u_if.ld3, u_if.ld2, u_if.ld1}, 12'h005);

      // pause keeps the prescaler value and lets direction move
      idle(4);
      press();
      chk("t4_run", u_if.state, 2'b01);
      wait_en(10, t1);
      chk("t4_en_seen", t1 > 0, 1'b1);
      press();
      chk("t4_pause", u_if.state, 2'b10);
      #1 base = en_cnt;
      u_if.dir_sel = 1'b0;
      @(negedge clk);
      chk("t4_dir_up", u_if.cnt_dir, 1'b0);
      u_if.dir_sel = 1'b1;
      @(negedge clk);
      chk("t4_dir_down", u_if.cnt_dir, 1'b1);
      idle(3);
      #1 chk("t4_pause_no_en", en_cnt - base, 0);
      press();
      t_run = cyc;
      chk("t4_resume", u_if.state, 2'b01);
      wait_en(10, t1);
      chk("t4_resume_en", t1 - t_run, 2);

      // load coincident with start_evt in PAUSE; 0xC clamps to 9
      press();
      chk("t5_pause", u_if.state, 2'b10);
      idle(4);
      u_if.preset1 = 4'hC;
      u_if.preset2 = 4'd3;
      u_if.preset3 = 4'd0;
      u_if.btn_start = 1'b1;
      idle(2);
      u_if.load = 1'b1;
      @(negedge clk);
      u_if.load = 1'b0;
      u_if.btn_start = 1'b0;
      chk("t5_idle", u_if.state, 2'b00);
      chk("t5_ld_strobe", u_if.cnt_ld, 1'b1);
      chk("t5_clamp", {u_if.ld3, u_if.ld2, u_if.ld1}, 12'h039);
      @(negedge clk);
      chk("t5_start_dropped", u_if.state, 2'b00);
      chk("t5_ld_once", u_if.cnt_ld, 1'b0);

      // asynchronous reset while a wrap is being decided
      idle(4);
      press();
      chk("t6_run", u_if.state, 2'b01);
      wait_en(10, t1);
      chk("t6_en_seen", t1 > 0, 1'b1);
      idle(3);
      rst = 1'b0;
      #1;
      chk("t6_async_state", u_if.state, 2'b00);
      chk("t6_async_en", u_if.cnt_en, 1'b0);
      base = strobe_cnt;
      idle(3);
      rst = 1'b1;
      idle(10);
      #1 chk("t6_no_strobe", strobe_cnt - base, 0);
      chk("t6_idle", u_if.state, 2'b00);

      chk("strobe_rules", viol, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
